// File: rtl/teclado_pkg.sv
// Shared definitions for the keypad entry path: key codes seen from the
// scanner and the state encoding of the press detector.
package teclado_pkg;

   localparam logic [4:0] TECLA_NINGUNA = 5'd16;
   localparam logic [3:0] TECLA_BORRAR  = 4'hA;
   localparam logic [3:0] TECLA_LIMPIAR = 4'hF;
   localparam logic [3:0] TECLA_ENTER   = 4'hE;

   typedef enum logic {
      ESPERA   = 1'b0,
      RETENIDA = 1'b1
   } estado_t;

endpackage

// File: rtl/detector_pulsacion.sv
// Press detector: turns the scanner's toggling key-seen flag into a single
// strobe per physical keystroke.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ESPERA   | no key held; the first valid key seen is latched and strobed
// RETENIDA | key held; waits for RELEASE_CYCLES consecutive idle cycles
//
// Ports:
//   clk, rst       clock, async active-high reset
//   digito         scanner key code (>=16 means no key)
//   cambio_digito  1 = no row active this cycle
//   tecla          accepted key code
//   tecla_valida   one-cycle strobe, tecla is valid with it
module detector_pulsacion
   import teclado_pkg::*;
#(
   parameter int RELEASE_CYCLES = 8,
   parameter int CNT_W          = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] digito,
   input  logic       cambio_digito,
   output logic [3:0] tecla,
   output logic       tecla_valida
);

   localparam logic [CNT_W-1:0] CNT_ULTIMO = CNT_W'(RELEASE_CYCLES - 1);

   estado_t          estado, estado_sig;
   logic [CNT_W-1:0] cnt;
   logic             tecla_vista;

   assign tecla_vista = !cambio_digito && (digito < TECLA_NINGUNA);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) estado <= ESPERA;
      else     estado <= estado_sig;
   end

   always_comb begin
      estado_sig = estado;
      case (estado)
         ESPERA:   if (tecla_vista) estado_sig = RETENIDA;
         RETENIDA: if (cambio_digito && cnt == CNT_ULTIMO) estado_sig = ESPERA;
         default:  estado_sig = ESPERA;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt          <= '0;
         tecla        <= '0;
         tecla_valida <= 1'b0;
      end else begin
         tecla_valida <= 1'b0;
         if (estado == ESPERA) begin
            if (tecla_vista) begin
               tecla        <= digito[3:0];
               tecla_valida <= 1'b1;
               cnt          <= '0;
            end
         end else if (cambio_digito) begin
            // Scan gaps are only three cycles, so only a real release reaches the end.
            cnt <= (cnt == CNT_ULTIMO) ? '0 : cnt + 1'b1;
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/keypad_entry_buffer.sv
// Keypad entry buffer: assembles BCD digits from debounced keystrokes with
// backspace (A), clear (F) and enter (E) editing.
//
// Ports:
//   clk, rst       clock, async active-high reset
//   digito         scanner key code, cambio_digito scanner idle flag
//   entrada        digits being edited, newest in [3:0]
//   cant_digitos   number of digits in entrada
//   valor          last committed number, valor_listo pulses on commit
//   tecla_pulso    pulses for every accepted keystroke
//   desborde       pulses when a digit is dropped because the buffer is full
module keypad_entry_buffer
   import teclado_pkg::*;
#(
   parameter int NUM_DIGITS     = 4,
   parameter int RELEASE_CYCLES = 8,
   parameter int CNT_W          = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4:0]              digito,
   input  logic                    cambio_digito,
   output logic [4*NUM_DIGITS-1:0] entrada,
   output logic [3:0]              cant_digitos,
   output logic [4*NUM_DIGITS-1:0] valor,
   output logic                    valor_listo,
   output logic                    tecla_pulso,
   output logic                    desborde
);

   localparam int         W         = 4 * NUM_DIGITS;
   localparam logic [3:0] MAX_DIGIT = 4'(NUM_DIGITS);

   logic [3:0] tecla;
   logic       tecla_valida;

   detector_pulsacion #(
      .RELEASE_CYCLES (RELEASE_CYCLES),
      .CNT_W          (CNT_W)
   ) u_detector (
      .clk           (clk),
      .rst           (rst),
      .digito        (digito),
      .cambio_digito (cambio_digito),
      .tecla         (tecla),
      .tecla_valida  (tecla_valida)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         entrada      <= '0;
         cant_digitos <= '0;
         valor        <= '0;
         valor_listo  <= 1'b0;
         tecla_pulso  <= 1'b0;
         desborde     <= 1'b0;
      end else begin
         valor_listo <= 1'b0;
         tecla_pulso <= 1'b0;
         desborde    <= 1'b0;
         if (tecla_valida) begin
            tecla_pulso <= 1'b1;
            if (tecla <= 4'd9) begin
               if (cant_digitos < MAX_DIGIT) begin
                  entrada      <= (entrada << 4) | W'(tecla);
                  cant_digitos <= cant_digitos + 4'd1;
               end else begin
                  desborde <= 1'b1;
               end
            end else if (tecla == TECLA_BORRAR) begin
               if (cant_digitos != 4'd0) begin
                  entrada      <= entrada >> 4;
                  cant_digitos <= cant_digitos - 4'd1;
               end
            end else if (tecla == TECLA_LIMPIAR) begin
               entrada      <= '0;
               cant_digitos <= '0;
            end else if (tecla == TECLA_ENTER) begin
               valor        <= entrada;
               valor_listo  <= 1'b1;
               entrada      <= '0;
               cant_digitos <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_keypad_entry_buffer.sv
module tb_keypad_entry_buffer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [4:0]  digito = 5'd16;
   logic        cambio_digito = 1'b1;
   logic [15:0] entrada;
   logic [3:0]  cant_digitos;
   logic [15:0] valor;
   logic        valor_listo;
   logic        tecla_pulso;
   logic        desborde;

   int n_chk  = 0;
   int n_pass = 0;
   int n_tp   = 0;
   int n_vl   = 0;
   int n_db   = 0;
   int n_b2b  = 0;
   logic prev_tp = 1'b0, prev_vl = 1'b0, prev_db = 1'b0;

   keypad_entry_buffer #(.NUM_DIGITS(4), .RELEASE_CYCLES(8), .CNT_W(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .digito        (digito),
      .cambio_digito (cambio_digito),
      .entrada       (entrada),
      .cant_digitos  (cant_digitos),
      .valor         (valor),
      .valor_listo   (valor_listo),
      .tecla_pulso   (tecla_pulso),
      .desborde      (desborde)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!rst) begin
         if (tecla_pulso) n_tp++;
         if (valor_listo) n_vl++;
         if (desborde)    n_db++;
         if ((tecla_pulso && prev_tp) || (valor_listo && prev_vl) || (desborde && prev_db))
            n_b2b++;
      end
      prev_tp = tecla_pulso;
      prev_vl = valor_listo;
      prev_db = desborde;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Scanner pattern while a key is held: row active one cycle in four.
   task automatic hold(input logic [4:0] key, input int n);
      for (int i = 0; i < n; i++) begin
         cambio_digito = (i % 4 != 0);
         digito        = (i % 4 == 0) ? key : 5'd16;
         cyc();
      end
   endtask

   task automatic soltar(input int n);
      cambio_digito = 1'b1;
      digito        = 5'd16;
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic tecla(input logic [4:0] key);
      hold(key, 12);
      soltar(12);
   endtask

   int tp0, db0;

   initial begin
      #1;
      chk("rst_entrada", 32'(entrada), 32'h0);
      chk("rst_cant", 32'(cant_digitos), 32'h0);
      chk("rst_valor", 32'(valor), 32'h0);
      chk("rst_pulses", {29'b0, valor_listo, tecla_pulso, desborde}, 32'h0);
      cyc(); cyc();
      rst = 1'b0;
      soltar(3);

      // long hold of 7 with scanning gaps: one keystroke only
      tp0 = n_tp;
      hold(5'd7, 40);
      soltar(10);
      chk("hold_tp", 32'(n_tp - tp0), 32'd1);
      chk("hold_entrada", 32'(entrada), 32'h0007);
      chk("hold_cant", 32'(cant_digitos), 32'd1);
      tecla(5'hF);
      chk("clear_cant", 32'(cant_digitos), 32'd0);

      // overflow on fifth digit
      tp0 = n_tp; db0 = n_db;
      tecla(5'd1); tecla(5'd2); tecla(5'd3); tecla(5'd4); tecla(5'd5);
      chk("full_entrada", 32'(entrada), 32'h1234);
      chk("full_cant", 32'(cant_digitos), 32'd4);
      chk("full_desborde", 32'(n_db - db0), 32'd1);
      chk("full_tp", 32'(n_tp - tp0), 32'd5);
      tecla(5'hF);

      // backspace then enter
      tecla(5'd1); tecla(5'd2); tecla(5'hA); tecla(5'd9);
      chk("bs_entrada", 32'(entrada), 32'h0019);
      chk("bs_cant", 32'(cant_digitos), 32'd2);
      tecla(5'hE);
      chk("ent_valor", 32'(valor), 32'h0019);
      chk("ent_vl", 32'(n_vl), 32'd1);
      chk("ent_entrada", 32'(entrada), 32'h0);
      chk("ent_cant", 32'(cant_digitos), 32'd0);

      // backspace on empty, clear, letter B
      tp0 = n_tp;
      tecla(5'hA); tecla(5'hF);
      chk("empty_cant", 32'(cant_digitos), 32'd0);
      chk("empty_entrada", 32'(entrada), 32'h0);
      chk("empty_tp", 32'(n_tp - tp0), 32'd2);
      tecla(5'hB);
      chk("b_tp", 32'(n_tp - tp0), 32'd3);
      chk("b_valor", 32'(valor), 32'h0019);
      chk("b_vl", 32'(n_vl), 32'd1);

      // invalid scanner code 17 is no key
      tp0 = n_tp;
      cambio_digito = 1'b0; digito = 5'd17;
      for (int i = 0; i < 6; i++) cyc();
      soltar(12);
      chk("inv_tp", 32'(n_tp - tp0), 32'd0);

      // enter with no digits commits zero
      tecla(5'hE);
      chk("ent0_valor", 32'(valor), 32'h0);
      chk("ent0_vl", 32'(n_vl), 32'd2);

      // reset in the middle of a hold of 3
      hold(5'd3, 12);
      chk("pre_rst_entrada", 32'(entrada), 32'h0003);
      cambio_digito = 1'b0; digito = 5'd3;
      rst = 1'b1;
      #1;
      chk("mid_rst_entrada", 32'(entrada), 32'h0);
      chk("mid_rst_cant", 32'(cant_digitos), 32'd0);
      chk("mid_rst_valor", 32'(valor), 32'h0);
      cyc(); cyc();
      rst = 1'b0;
      hold(5'd3, 12);
      soltar(12);
      chk("post_rst_entrada", 32'(entrada), 32'h0003);
      chk("post_rst_cant", 32'(cant_digitos), 32'd1);

      chk("no_back_to_back", 32'(n_b2b), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
